// File: rtl/cap_board_pkg.sv
// Shared types, helpers and parameter legality checks for the capacitor-bank board.
package cap_board_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // True when the generic set describes a buildable board.
    function automatic bit params_ok(input int unsigned num_banks,
                                     input int unsigned div_log2,
                                     input int unsigned dead_cycles,
                                     input int unsigned settle_cycles);
        return (num_banks >= 1) && (num_banks <= 16) && (div_log2 >= 1) &&
               (dead_cycles < (32'd1 << div_log2)) && (settle_cycles >= 1);
    endfunction

endpackage

// File: rtl/cap_bank_phase_driver.sv
// Push-pull gate-drive generator: shared divider, dead time, boundary-gated bank enables.
module cap_bank_phase_driver
    import cap_board_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned DIV_LOG2    = 2,
    parameter int unsigned DEAD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BANKS-1:0] bank_state,
    output logic [NUM_BANKS-1:0] drive_a,
    output logic [NUM_BANKS-1:0] drive_b
);

    localparam int unsigned DIV_W = DIV_LOG2 + 1;

    logic [DIV_W-1:0]     div_cnt;
    logic [NUM_BANKS-1:0] gate;
    logic [DIV_LOG2-1:0]  sub_c;
    logic                 phase_c;
    logic                 dead_c;
    logic [NUM_BANKS-1:0] gate_nxt_c;

    // Phase decode; gate only follows bank_state at a half-period boundary.
    always_comb begin
        sub_c      = div_cnt[DIV_LOG2-1:0];
        phase_c    = div_cnt[DIV_LOG2];
        dead_c     = (sub_c < DIV_LOG2'(DEAD_CYCLES));
        gate_nxt_c = (sub_c == '0) ? bank_state : gate;
    end

    // Divider, gate latch and registered complementary drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            gate    <= '0;
            drive_a <= '0;
            drive_b <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            gate    <= gate_nxt_c;
            drive_a <= gate_nxt_c & {NUM_BANKS{phase_c & ~dead_c}};
            drive_b <= gate_nxt_c & {NUM_BANKS{~phase_c & ~dead_c}};
        end
    end

endmodule

// File: rtl/cap_bank_sequencer.sv
// Board top: input synchronisers, tuning-code decode, one-bank-at-a-time switching FSM.
module cap_bank_sequencer
    import cap_board_pkg::*;
#(
    parameter int unsigned NUM_BANKS     = 4,
    parameter int unsigned CODE_W        = 7,
    parameter int unsigned BOARD_ID_W    = 6,
    parameter int unsigned DIV_LOG2      = 2,
    parameter int unsigned DEAD_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BOARD_ID_W-1:0] boardId,
    input  logic                  enable,
    input  logic [CODE_W-1:0]     tuningCode,
    output logic [NUM_BANKS-1:0]  driveA,
    output logic [NUM_BANKS-1:0]  driveB,
    output logic [NUM_BANKS-1:0]  bankState,
    output logic                  busy,
    output logic                  stepDone
);

    localparam int unsigned NB_W   = clog2(NUM_BANKS);
    localparam int unsigned BASE_W = CODE_W + BOARD_ID_W + NB_W;
    localparam int unsigned CMP_W  = BASE_W + 1;
    localparam int unsigned CNT_W  = clog2(SETTLE_CYCLES + 1);

    if (!params_ok(NUM_BANKS, DIV_LOG2, DEAD_CYCLES, SETTLE_CYCLES)) begin : g_param_check
        $error("cap_bank_sequencer: illegal parameter set");
    end

    logic                  en_s1, en_s2;
    logic [CODE_W-1:0]     code_s1, code_s2, code_prev;
    logic [BOARD_ID_W-1:0] id_s1, id_s2;
    logic [NUM_BANKS-1:0]  target;
    logic [CNT_W-1:0]      settle_cnt;
    seq_state_t            state, state_nxt;

    logic [CMP_W-1:0]      base_c;
    logic [NUM_BANKS-1:0]  decode_c, target_nxt_c;
    logic [NUM_BANKS-1:0]  off_c, on_c, clr_mask_c, set_mask_c;
    logic [NUM_BANKS-1:0]  bank_nxt_c;
    logic                  do_step_c, settle_last_c, busy_nxt_c;

    // Thermometer decode of the code relative to this board's base address.
    always_comb begin
        base_c   = CMP_W'(id_s2) * CMP_W'(NUM_BANKS);
        decode_c = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            decode_c[i] = (CMP_W'(code_s2) > (base_c + CMP_W'(i)));
        end
        target_nxt_c = (en_s2 && (code_s2 == code_prev)) ? decode_c : target;
    end

    // Synchronisers, glitch filter and target register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1     <= 1'b0;
            en_s2     <= 1'b0;
            code_s1   <= '0;
            code_s2   <= '0;
            code_prev <= '0;
            id_s1     <= '0;
            id_s2     <= '0;
            target    <= '0;
        end else begin
            en_s1     <= enable;
            en_s2     <= en_s1;
            code_s1   <= tuningCode;
            code_s2   <= code_s1;
            code_prev <= code_s2;
            id_s1     <= boardId;
            id_s2     <= id_s1;
            target    <= target_nxt_c;
        end
    end

    // Pick the highest bank to drop and the lowest bank to add.
    always_comb begin
        off_c      = bankState & ~target;
        on_c       = ~bankState & target;
        clr_mask_c = '0;
        set_mask_c = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (off_c[i]) begin
                clr_mask_c    = '0;
                clr_mask_c[i] = 1'b1;
            end
        end
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (on_c[i]) begin
                set_mask_c    = '0;
                set_mask_c[i] = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bankState != target) state_nxt = STEP;
            STEP:    state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the single-bit bank change and next busy level.
    always_comb begin
        do_step_c     = (state == STEP);
        settle_last_c = (state == SETTLE) && (settle_cnt == CNT_W'(1));
        bank_nxt_c    = bankState;
        if (do_step_c) begin
            bank_nxt_c = (|off_c) ? (bankState & ~clr_mask_c) : (bankState | set_mask_c);
        end
        busy_nxt_c = (bank_nxt_c != target_nxt_c) || (state_nxt != IDLE);
    end

    // Committed bank state, settle timer and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bankState  <= '0;
            settle_cnt <= '0;
            stepDone   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bankState <= bank_nxt_c;
            stepDone  <= settle_last_c;
            busy      <= busy_nxt_c;
            if (do_step_c)               settle_cnt <= CNT_W'(SETTLE_CYCLES);
            else if (state == SETTLE)    settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    cap_bank_phase_driver #(
        .NUM_BANKS  (NUM_BANKS),
        .DIV_LOG2   (DIV_LOG2),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_driver (
        .clk       (clk),
        .rst       (rst),
        .bank_state(bankState),
        .drive_a   (driveA),
        .drive_b   (driveB)
    );

endmodule

// File: tb/tb_cap_bank_sequencer.sv
// Directed bench for cap_bank_sequencer with default parameters.
module tb_cap_bank_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [5:0] boardId;
    logic       enable;
    logic [6:0] tuningCode;
    logic [3:0] driveA, driveB, bankState;
    logic       busy, stepDone;

    int vectors;
    int errors;

    cap_bank_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .boardId   (boardId),
        .enable    (enable),
        .tuningCode(tuningCode),
        .driveA    (driveA),
        .driveB    (driveB),
        .bankState (bankState),
        .busy      (busy),
        .stepDone  (stepDone)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run) clk = ~clk;
    end

    typedef struct {
        logic [5:0] id;
        logic       en;
        logic [6:0] code;
        logic [3:0] exp_bank;
        logic [3:0] exp_first;
        int         exp_steps;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Let a new setting propagate, then run until busy drops.
    task automatic run_to_idle(output logic [3:0] first, output int steps,
                               output int overlap, output bit timeout);
        logic [3:0] prev;
        bit         seen;
        int         n;
        prev    = bankState;
        first   = bankState;
        seen    = 0;
        steps   = 0;
        overlap = 0;
        timeout = 1;
        n       = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (stepDone) steps++;
            if ((driveA & driveB) != 4'b0) overlap++;
            if (!seen && bankState != prev) begin
                first = bankState;
                seen  = 1;
            end
            if (n >= 6 && !busy) begin
                timeout = 0;
                break;
            end
        end
    endtask

    initial begin
        vec_t       tbl [13];
        logic [3:0] first;
        int         steps, overlap;
        bit         timeout;
        int         chg_at [4];
        int         nchg;
        int         done_cnt;
        logic [3:0] prev;
        logic [15:0] cap_a, cap_b, exp_a, exp_b;
        bit         any_out, busy_seen, found;

        vectors = 0;
        errors  = 0;

        tbl[0]  = '{6'd1,  1'b1, 7'd6,   4'b0011, 4'b0111, 2};
        tbl[1]  = '{6'd1,  1'b1, 7'd4,   4'b0000, 4'b0001, 2};
        tbl[2]  = '{6'd1,  1'b0, 7'd20,  4'b0000, 4'b0000, 0};
        tbl[3]  = '{6'd1,  1'b1, 7'd20,  4'b1111, 4'b0001, 4};
        tbl[4]  = '{6'd1,  1'b1, 7'd3,   4'b0000, 4'b0111, 4};
        tbl[5]  = '{6'd0,  1'b1, 7'd2,   4'b0011, 4'b0001, 2};
        tbl[6]  = '{6'd0,  1'b0, 7'd7,   4'b0011, 4'b0011, 0};
        tbl[7]  = '{6'd2,  1'b1, 7'd9,   4'b0001, 4'b0001, 1};
        tbl[8]  = '{6'd2,  1'b1, 7'd8,   4'b0000, 4'b0000, 1};
        tbl[9]  = '{6'd31, 1'b1, 7'd127, 4'b0111, 4'b0001, 3};
        tbl[10] = '{6'd63, 1'b1, 7'd127, 4'b0000, 4'b0011, 3};
        tbl[11] = '{6'd0,  1'b1, 7'd127, 4'b1111, 4'b0001, 4};
        tbl[12] = '{6'd0,  1'b1, 7'd0,   4'b0000, 4'b0111, 4};

        // Reset with the clock stopped.
        run        = 1'b0;
        rst        = 1'b1;
        boardId    = 6'd1;
        enable     = 1'b0;
        tuningCode = 7'd6;
        #1;
        check("rst_driveA", 32'(driveA), 32'h0);
        check("rst_driveB", 32'(driveB), 32'h0);
        check("rst_bank", 32'(bankState), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        any_out = 0;
        repeat (100) begin
            @(negedge clk);
            if (driveA != 0 || driveB != 0 || bankState != 0 || busy || stepDone) any_out = 1;
        end
        check("idle_outputs_quiet", 32'(any_out), 32'h0);

        // Power-up sequence and step spacing.
        enable   = 1'b1;
        nchg     = 0;
        done_cnt = 0;
        prev     = bankState;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (stepDone) done_cnt++;
            if (bankState != prev) begin
                if (nchg < 4) chg_at[nchg] = n;
                if (nchg == 0) check("first_step", 32'(bankState), 32'h1);
                if (nchg == 1) check("second_step", 32'(bankState), 32'h3);
                nchg++;
                prev = bankState;
            end
            if (n >= 6 && !busy) break;
        end
        check("seq_change_count", 32'(nchg), 32'd2);
        if (nchg >= 2) check("step_spacing", 32'(chg_at[1] - chg_at[0]), 32'd18);
        check("seq_stepdone_count", 32'(done_cnt), 32'd2);
        check("seq_final_bank", 32'(bankState), 32'h3);
        check("seq_busy_low", 32'(busy), 32'h0);

        // Drive waveform on bank 0: align to a rising driveA edge.
        found = 0;
        prev  = driveA;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (driveA[0] && !prev[0]) found = 1;
            prev = driveA;
        end
        check("wave_align", 32'(found), 32'h1);
        for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            cap_a[k] = driveA[0];
            cap_b[k] = driveB[0];
            exp_a[k] = ((k % 8) < 3);
            exp_b[k] = ((k % 8) >= 4) && ((k % 8) < 7);
        end
        check("wave_driveA", 32'(cap_a), 32'(exp_a));
        check("wave_driveB", 32'(cap_b), 32'(exp_b));
        check("wave_no_overlap", 32'(cap_a & cap_b), 32'h0);

        // One-cycle code glitch must be filtered.
        busy_seen = 0;
        tuningCode = 7'd20;
        @(negedge clk);
        tuningCode = 7'd6;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("glitch_bank", 32'(bankState), 32'h3);
        check("glitch_no_busy", 32'(busy_seen), 32'h0);

        // Code changes with enable low are ignored.
        enable = 1'b0;
        repeat (5) @(negedge clk);
        tuningCode = 7'd20;
        busy_seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("en_low_bank", 32'(bankState), 32'h3);
        check("en_low_no_busy", 32'(busy_seen), 32'h0);

        // Reset in the middle of a settle interval.
        enable = 1'b1;
        found  = 0;
        prev   = bankState;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (bankState != prev) found = 1;
        end
        check("midrst_step_seen", 32'(bankState), 32'h7);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_bank", 32'(bankState), 32'h0);
        check("midrst_drives", 32'({driveA, driveB}), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_to_idle(first, steps, overlap, timeout);
        check("midrst_timeout", 32'(timeout), 32'h0);
        check("midrst_resequence", 32'(bankState), 32'hF);
        check("midrst_first", 32'(first), 32'h1);
        check("midrst_steps", 32'(steps), 32'd4);

        // Table of directed settings.
        for (int i = 0; i < 13; i++) begin
            boardId    = tbl[i].id;
            enable     = tbl[i].en;
            tuningCode = tbl[i].code;
            run_to_idle(first, steps, overlap, timeout);
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'h0);
            check($sformatf("v%0d_bank", i), 32'(bankState), 32'(tbl[i].exp_bank));
            check($sformatf("v%0d_first", i), 32'(first), 32'(tbl[i].exp_first));
            check($sformatf("v%0d_steps", i), 32'(steps), 32'(tbl[i].exp_steps));
            check($sformatf("v%0d_overlap", i), 32'(overlap), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
